// File: rtl/fault_test_pkg.sv
// Shared widths, state encoding and settle-time limits for the stuck-at fault test sequencer.
package fault_test_pkg;

  localparam int unsigned VEC_W       = 3;
  localparam int unsigned OUT_W       = 2;
  localparam int unsigned NUM_VEC     = 8;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned FCNT_W      = 4;
  localparam int unsigned SETTLE_MIN  = 1;
  localparam int unsigned SETTLE_MAX  = 15;

  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fault_test_sequencer_if.sv
// Lab-control and CUT-facing signal bundle of the fault test sequencer.
interface fault_test_sequencer_if;
  import fault_test_pkg::*;

  logic                 start;
  logic                 stop_on_fail;
  logic [VEC_W-1:0]     vec_out;
  logic [OUT_W-1:0]     good_f;
  logic [OUT_W-1:0]     cut_f;
  logic                 busy;
  logic                 done;
  logic                 fault_detected;
  logic [VEC_W-1:0]     first_fail_vec;
  logic [NUM_VEC-1:0]   fail_mask;
  logic [FCNT_W-1:0]    fail_count;
  logic [OUT_W-1:0]     diff_accum;

  // Lab controller and the two CUT instances
  modport master (
    output start, stop_on_fail, good_f, cut_f,
    input  vec_out, busy, done, fault_detected, first_fail_vec,
           fail_mask, fail_count, diff_accum
  );

  // Sequencer
  modport slave (
    input  start, stop_on_fail, good_f, cut_f,
    output vec_out, busy, done, fault_detected, first_fail_vec,
           fail_mask, fail_count, diff_accum
  );

endinterface

// File: rtl/fault_result_recorder.sv
// Accumulates per-run detection results from each compared vector.
module fault_result_recorder
  import fault_test_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_capture,
  input  logic [VEC_W-1:0]    i_vec,
  input  logic [OUT_W-1:0]    i_diff,
  output logic                o_fault_detected,
  output logic [VEC_W-1:0]    o_first_fail_vec,
  output logic [NUM_VEC-1:0]  o_fail_mask,
  output logic [FCNT_W-1:0]   o_fail_count,
  output logic [OUT_W-1:0]    o_diff_accum
);

  logic                r_fault_detected;
  logic [VEC_W-1:0]    r_first_fail_vec;
  logic [NUM_VEC-1:0]  r_fail_mask;
  logic [FCNT_W-1:0]   r_fail_count;
  logic [OUT_W-1:0]    r_diff_accum;
  logic                w_mismatch;

  assign w_mismatch = |i_diff;

  // Count cannot exceed NUM_VEC because each vector is captured at most once per run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_detected <= 1'b0;
      r_first_fail_vec <= '0;
      r_fail_mask      <= '0;
      r_fail_count     <= '0;
      r_diff_accum     <= '0;
    end else if (i_clear) begin
      r_fault_detected <= 1'b0;
      r_first_fail_vec <= '0;
      r_fail_mask      <= '0;
      r_fail_count     <= '0;
      r_diff_accum     <= '0;
    end else if (i_capture) begin
      r_diff_accum <= r_diff_accum | i_diff;
      if (w_mismatch) begin
        r_fail_mask[i_vec] <= 1'b1;
        r_fail_count       <= FCNT_W'(r_fail_count + FCNT_W'(1));
        if (!r_fault_detected) begin
          r_first_fail_vec <= i_vec;
          r_fault_detected <= 1'b1;
        end
      end
    end
  end

  assign o_fault_detected = r_fault_detected;
  assign o_first_fail_vec = r_first_fail_vec;
  assign o_fail_mask      = r_fail_mask;
  assign o_fail_count     = r_fail_count;
  assign o_diff_accum     = r_diff_accum;

endmodule

// File: rtl/fault_test_sequencer.sv
// Walks all CUT input vectors, waits a settle time per vector and compares good vs faulty outputs.
module fault_test_sequencer
  import fault_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fault_test_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [VEC_W-1:0]    r_vec;
  logic [VEC_W-1:0]    w_vec_nxt;
  logic                r_stop;
  logic                w_stop_nxt;
  logic                r_busy;
  logic                r_done;
  logic                w_clear;
  logic                w_capture;
  logic [OUT_W-1:0]    w_diff;

  assign w_diff = bus.good_f ^ bus.cut_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_stop  <= w_stop_nxt;
      r_busy  <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_COMPARE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Start is honoured only when idle or finished; a run in flight ignores it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_stop_nxt  = r_stop;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_clear     = 1'b1;
          w_vec_nxt   = '0;
          w_stop_nxt  = bus.stop_on_fail;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_COMPARE;
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt - CNT_W'(1));
        end
      end
      ST_COMPARE: begin
        w_capture = 1'b1;
        if ((r_vec == VEC_LAST) || (r_stop && (w_diff != '0))) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_nxt   = VEC_W'(r_vec + VEC_W'(1));
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_SETTLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  fault_result_recorder u_recorder (
    .clk              (clk),
    .rst              (rst),
    .i_clear          (w_clear),
    .i_capture        (w_capture),
    .i_vec            (r_vec),
    .i_diff           (w_diff),
    .o_fault_detected (bus.fault_detected),
    .o_first_fail_vec (bus.first_fail_vec),
    .o_fail_mask      (bus.fail_mask),
    .o_fail_count     (bus.fail_count),
    .o_diff_accum     (bus.diff_accum)
  );

  assign bus.vec_out = r_vec;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_fault_test_sequencer.sv
// Randomized and directed bench for fault_test_sequencer against a per-vector reference model.
module tb_fault_test_sequencer;

  logic clk;
  logic rst;

  logic [1:0] good_tbl [8];
  logic [1:0] cut_tbl  [8];

  int n_cmp;
  int n_err;

  logic [2:0] o_vec;
  logic       o_busy;
  logic       o_done;
  logic       o_fd;
  logic [2:0] o_first;
  logic [7:0] o_mask;
  logic [3:0] o_cnt;
  logic [1:0] o_diff;

  fault_test_sequencer_if ifa ();
  fault_test_sequencer_if ifb ();

  fault_test_sequencer #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fault_test_sequencer #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Both CUT models respond combinationally to the vector each sequencer drives
  assign ifa.good_f = good_tbl[ifa.vec_out];
  assign ifa.cut_f  = cut_tbl[ifa.vec_out];
  assign ifb.good_f = good_tbl[ifb.vec_out];
  assign ifb.cut_f  = cut_tbl[ifb.vec_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      o_vec = ifa.vec_out; o_busy = ifa.busy; o_done = ifa.done; o_fd = ifa.fault_detected;
      o_first = ifa.first_fail_vec; o_mask = ifa.fail_mask; o_cnt = ifa.fail_count; o_diff = ifa.diff_accum;
    end else begin
      o_vec = ifb.vec_out; o_busy = ifb.busy; o_done = ifb.done; o_fd = ifb.fault_detected;
      o_first = ifb.first_fail_vec; o_mask = ifb.fail_mask; o_cnt = ifb.fail_count; o_diff = ifb.diff_accum;
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v; else ifb.start = v;
  endtask

  task automatic set_stop(input int sel, input logic v);
    if (sel == 0) ifa.stop_on_fail = v; else ifb.stop_on_fail = v;
  endtask

  task automatic tables_clean();
    for (int v = 0; v < 8; v++) begin
      good_tbl[v] = 2'($urandom_range(0, 3));
      cut_tbl[v]  = good_tbl[v];
    end
  endtask

  task automatic tables_random();
    for (int v = 0; v < 8; v++) begin
      good_tbl[v] = 2'($urandom_range(0, 3));
      cut_tbl[v]  = good_tbl[v] ^ (($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vec"},   32'(o_vec),   32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
    chk({tag, "_fd"},    32'(o_fd),    32'd0);
    chk({tag, "_first"}, 32'(o_first), 32'd0);
    chk({tag, "_mask"},  32'(o_mask),  32'd0);
    chk({tag, "_cnt"},   32'(o_cnt),   32'd0);
    chk({tag, "_diff"},  32'(o_diff),  32'd0);
  endtask

  // One full run: model computes expected results and done cycle, then the run is tracked cycle by cycle
  task automatic run(input int sel, input logic stop, input int inj);
    int         s;
    int         last;
    int         dc;
    logic [7:0] e_mask;
    int         e_cnt;
    int         e_first;
    logic       e_fd;
    logic [1:0] e_diff;
    logic [1:0] d;
    s = (sel == 0) ? 2 : 1;
    e_mask = '0; e_cnt = 0; e_first = 0; e_fd = 1'b0; e_diff = '0; last = 7;
    for (int v = 0; v < 8; v++) begin
      d = good_tbl[v] ^ cut_tbl[v];
      e_diff = e_diff | d;
      if (d != 2'b00) begin
        if (!e_fd) e_first = v;
        e_fd = 1'b1;
        e_mask[v] = 1'b1;
        e_cnt++;
      end
      if (stop && d != 2'b00) begin
        last = v;
        break;
      end
    end
    dc = (last + 1) * (s + 1);

    @(negedge clk);
    set_start(sel, 1'b1);
    set_stop(sel, stop);
    for (int t = 0; t <= dc; t++) begin
      @(posedge clk);
      @(negedge clk);
      set_start(sel, (t == inj && t <= dc - 2) ? 1'b1 : 1'b0);
      if (t == 0) set_stop(sel, ~stop);
      sample(sel);
      if (t < dc) begin
        chk("vec_step", 32'(o_vec),  32'(t / (s + 1)));
        chk("busy_run", 32'(o_busy), 32'd1);
        chk("done_run", 32'(o_done), 32'd0);
        if (t == 0) begin
          chk("clr_mask", 32'(o_mask), 32'd0);
          chk("clr_fd",   32'(o_fd),   32'd0);
          chk("clr_cnt",  32'(o_cnt),  32'd0);
          chk("clr_diff", 32'(o_diff), 32'd0);
        end
      end else begin
        chk("done_end",  32'(o_done),  32'd1);
        chk("busy_end",  32'(o_busy),  32'd0);
        chk("vec_end",   32'(o_vec),   32'(last));
        chk("fd_end",    32'(o_fd),    32'(e_fd));
        chk("first_end", 32'(o_first), 32'(e_first));
        chk("mask_end",  32'(o_mask),  32'(e_mask));
        chk("cnt_end",   32'(o_cnt),   32'(e_cnt));
        chk("diff_end",  32'(o_diff),  32'(e_diff));
      end
    end
    @(negedge clk);
    sample(sel);
    chk("done_hold", 32'(o_done), 32'd1);
    chk("mask_hold", 32'(o_mask), 32'(e_mask));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.stop_on_fail = 1'b0;
    ifb.start = 1'b0; ifb.stop_on_fail = 1'b0;
    tables_clean();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sample(0); check_zero("rst_a");
    sample(1); check_zero("rst_b");

    // Clean CUT, then single F1 fault on vector 5
    tables_clean();
    run(0, 1'b0, -1);
    tables_clean();
    cut_tbl[5] = good_tbl[5] ^ 2'b10;
    run(0, 1'b0, -1);

    // Faults on vectors 2 (F0) and 6 (F1), with and without early stop
    tables_clean();
    cut_tbl[2] = good_tbl[2] ^ 2'b01;
    cut_tbl[6] = good_tbl[6] ^ 2'b10;
    run(0, 1'b1, -1);
    run(0, 1'b0, 5);

    // Asynchronous reset in the middle of a run
    tables_random();
    @(negedge clk);
    set_start(0, 1'b1);
    set_stop(0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    sample(0); check_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sample(0);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_done", 32'(o_done), 32'd0);

    // Short settle instance: run from idle, then restart from done
    tables_clean();
    cut_tbl[3] = good_tbl[3] ^ 2'b11;
    run(1, 1'b0, -1);
    tables_random();
    run(1, 1'b0, 4);

    // Randomized runs on both instances, including mid-run start pulses
    for (int i = 0; i < 20; i++) begin
      tables_random();
      run(0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    for (int i = 0; i < 8; i++) begin
      tables_random();
      run(1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fault_test_sequencer.md
Name: fault_test_sequencer

Overview:
Sequencer for stuck-at fault detection on the 3-input / 2-output circuit under test (CUT).
- Walks all 8 input vectors (A,B,C) in ascending order.
- Drives each vector to the fault-free circuit and the faulty circuit at the same time.
- After a programmable settle time, compares their F0/F1 outputs.
- Records which vectors detect the fault.
- Sits between the top-level lab controls (start button, LEDs) and the two CUT instances.

Parameters:
SETTLE_CYCLES, 2, cycles a vector is held before compare; legal range 1..15
NUM_VEC, 8, vectors per run (2^3, fixed by the CUT input width)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  run request; sampled in IDLE and DONE only
stop_on_fail  in  1  1 = end the run at the first detecting vector; sampled with start
vec_out  out  3  {A,B,C} driven to both circuits; registered
good_f  in  2  {F1,F0} from the fault-free circuit
cut_f  in  2  {F1,F0} from the faulty circuit
busy  out  1  high in SETTLE and COMPARE
done  out  1  high in DONE
fault_detected  out  1  at least one vector mismatched in this run
first_fail_vec  out  3  index of the first mismatching vector; 0 if none
fail_mask  out  8  bit i set if vector i mismatched
fail_count  out  4  number of mismatching vectors, 0..8
diff_accum  out  2  OR of (good_f ^ cut_f) over all compared vectors

Behaviour:
- Reset (async, any state) sets every output to 0 and the FSM to IDLE.
  - Reset mid-run aborts the run; no partial results are retained.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE, start=1:
  - vec_out<=0; all result outputs cleared; stop_on_fail latched.
  - settle counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - vec_out held stable.
  - Counter==0 -> COMPARE; otherwise decrement.
  - Exactly SETTLE_CYCLES cycles in this state.
- COMPARE (one cycle): d = good_f ^ cut_f, sampled this cycle. Registered at the exit edge:
  - diff_accum |= d.
  - If d!=0:
    - fail_mask[vec_out]<=1; fail_count++.
    - If fault_detected was 0: first_fail_vec<=vec_out and fault_detected<=1.
- COMPARE exit:
  - If vec_out==7, or (latched stop_on_fail and d!=0): go to DONE; vec_out holds.
  - Otherwise: vec_out<=vec_out+1; counter reloaded; go to SETTLE.
- Per-vector cost is SETTLE_CYCLES+1 cycles.
  - Full run: done=1 in cycle 8*(SETTLE_CYCLES+1) after the start edge (24 for the default).
- DONE:
  - done=1; results held stable.
  - start=1 restarts exactly as from IDLE: results cleared on the same edge, done=0 the next cycle.
- start while busy is ignored; no queuing.
- Width rules:
  - vec_out does not wrap within a run.
  - fail_count saturates naturally at 8 (4 bits).
  - fail_mask index equals vec_out.
- good_f and cut_f are treated as combinational responses to vec_out.
  - No synchronizer is applied.
  - SETTLE_CYCLES covers propagation.

Decomposition:
- Package fault_test_pkg holds:
  - state encoding (IDLE=0, SETTLE=1, COMPARE=2, DONE=3)
  - NUM_VEC
  - VEC_W=3, OUT_W=2
  - the SETTLE_CYCLES legal range
- Sub-module fault_result_recorder:
  - Holds fail_mask, fail_count, first_fail_vec, fault_detected and diff_accum.
  - Inputs: clear, capture, vec index, diff.
- The top contains only the FSM, settle counter and vec_out register.

Test Plan:
1. good_f==cut_f for all vectors, start pulse at cycle 0, default params -> vec_out steps 0..7, done=1 at cycle 24; fault_detected=0, fail_mask=8'h00, fail_count=0, diff_accum=2'b00.
2. cut_f differs from good_f only on F1 when vec_out==5 -> fail_mask=8'b0010_0000, first_fail_vec=5, fail_count=1, diff_accum=2'b10, done at cycle 24.
3. Mismatch on vectors 2 (F0) and 6 (F1), stop_on_fail=1 -> run ends after vector 2: done at cycle 9, fail_mask=8'b0000_0100, fail_count=1, diff_accum=2'b01, vec_out=2.
4. Same stimulus with stop_on_fail=0 -> fail_mask=8'b0100_0100, first_fail_vec=2, fail_count=2, diff_accum=2'b11.
5. rst pulsed at cycle 10 of a run -> all outputs 0 immediately (asynchronous); start pulse while busy -> ignored, vec sequence and done timing unchanged.
6. From DONE with results set, start=1 -> results clear on that edge, done=0 the next cycle, new run completes normally. Repeat with SETTLE_CYCLES=1 -> done at cycle 16.
